addr_inv_gen: RTL and testbench
===============================

ADDR_INV_GEN -- requirements
Module: addr_inv_gen

Interface
REQ-001 Parameter ADDRLENGTH, default 12, address width; 12 is the only supported value (4096-entry frame).
REQ-002 clk  input  1  clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 mode  input  3  stage select 0..7; latched on an accepted start.
REQ-006 abort  input  1  synchronous frame cancel.
REQ-007 out_ready  input  1  downstream ready for addr.
REQ-008 addr_valid  output  1  addr/linear_addr hold a valid read address.
REQ-009 addr  output  12  de-interleaved (inverse-permuted) read address.
REQ-010 linear_addr  output  12  current linear index (the counter value).
REQ-011 frame_done  output  1  one-cycle pulse after the last address handshake.
REQ-012 busy  output  1  high in RUN.

Function
REQ-013 The FSM SHALL have two states: IDLE and RUN.
REQ-014 IDLE -> RUN when start=1 and abort=0; mode latched into mode_q; count=0.
REQ-015 In RUN, addr_valid SHALL be 1, and addr_valid SHALL first assert in the cycle after start is accepted.
REQ-016 A handshake SHALL be addr_valid=1 and out_ready=1; count increments by 1 per handshake only.
REQ-017 While out_ready=0, count, addr and linear_addr SHALL hold stable.
REQ-018 addr SHALL be a combinational function of count c and mode_q:
- mode 0: {c[9:0],c[11:10]}
- mode 1: {c[11:10],c[7:0],c[9:8]}
- mode 2: {c[11:8],c[5:0],c[7:6]}
- mode 3: {c[11:6],c[3:0],c[5:4]}
- mode 4: {c[11:4],c[1:0],c[3:2]}
- mode 5 and mode 7: c
- mode 6: base-4 digit reversal {c[1:0],c[3:2],c[5:4],c[7:6],c[9:8],c[11:10]}
REQ-019 Each mode SHALL be the exact inverse of the matching write-side interleaver permutation for that stage.
REQ-020 Handshake at count=4095: count wraps to 0, FSM -> IDLE, and frame_done=1 for the following cycle.
REQ-021 abort=1 in RUN SHALL force IDLE and count=0 next cycle with no frame_done, including when it coincides with the count=4095 handshake.
REQ-022 start or mode changes during RUN SHALL be ignored; start=1 with abort=1 in IDLE SHALL be ignored.
REQ-023 In IDLE: addr_valid=0, busy=0, count=0, addr=0.

Reset
REQ-024 rst=0 SHALL asynchronously force IDLE, count=0 and mode_q=0.
REQ-025 Reset values: addr_valid=0, addr=0, linear_addr=0, frame_done=0, busy=0.
REQ-026 Reset asserted mid-frame SHALL discard the frame; no frame_done is produced.
REQ-027 After rst deasserts, the block SHALL remain in IDLE until a new start is accepted.

Configuration
REQ-028 The macro ADDR_INV_AUTORESTART_EN SHALL control frame restart.
REQ-029 With ADDR_INV_AUTORESTART_EN defined, the count=4095 handshake SHALL wrap count to 0 and stay in RUN with the same mode_q.
- frame_done still pulses for that cycle.
- addr_valid stays 1 with no gap.
- Only abort or reset returns the FSM to IDLE.
REQ-030 Without ADDR_INV_AUTORESTART_EN, the behaviour SHALL be exactly as in REQ-020.

Verification
REQ-031 Reset, then start with mode=0 and out_ready=1 -> addr sequence 0x000, 0x004, 0x008; addr_valid rises 1 cycle after start.
REQ-032 mode=6, linear_addr=0x001 -> addr=0x400; mode=1, linear_addr=0x100 -> addr=0x001; mode=3, linear_addr=0x010 -> addr=0x001.
REQ-033 out_ready held 0 for 5 cycles at linear_addr=0x123 -> addr and linear_addr stable for those 5 cycles; count advances only after out_ready=1.
REQ-034 Full frame with mode=4 -> 4096 handshakes, then a single frame_done pulse, busy=0, and all 4096 addr values distinct.
REQ-035 abort together with the count=4095 handshake -> IDLE, frame_done stays 0; with ADDR_INV_AUTORESTART_EN and no abort -> linear_addr 0x000 on the next cycle with addr_valid=1.
REQ-036 rst pulsed low at linear_addr=0x800 -> all outputs 0 immediately; the block stays idle until the next start.

Source files
------------

// File: rtl/addr_inv_gen.sv
// ============================================================================
// Module   : addr_inv_gen
// Brief    : De-interleaver read-address generator for one 4096-entry frame.
//            Optional macro ADDR_INV_AUTORESTART_EN keeps running frame after frame.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module addr_inv_gen #(
  parameter int ADDRLENGTH = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            mode,
  input  logic                  abort,
  input  logic                  out_ready,
  output logic                  addr_valid,
  output logic [ADDRLENGTH-1:0] addr,
  output logic [ADDRLENGTH-1:0] linear_addr,
  output logic                  frame_done,
  output logic                  busy
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [ADDRLENGTH-1:0] C_LAST = '1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDRLENGTH-1:0] r_count;
  logic [ADDRLENGTH-1:0] w_count_nxt;
  logic [2:0]            r_mode_q;
  logic [2:0]            w_mode_nxt;
  logic                  r_frame_done;
  logic                  w_frame_done_nxt;
  logic [ADDRLENGTH-1:0] w_perm;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_mode_q     <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_count      <= w_count_nxt;
      r_mode_q     <= w_mode_nxt;
      r_frame_done <= w_frame_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_count_nxt      = r_count;
    w_mode_nxt       = r_mode_q;
    w_frame_done_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start && !abort) begin
          w_state_nxt = S_RUN;
          w_count_nxt = '0;
          w_mode_nxt  = mode;
        end
      end
      S_RUN: begin
        // Abort wins over the final handshake: the frame is dropped silently.
        if (abort) begin
          w_state_nxt = S_IDLE;
          w_count_nxt = '0;
        end else if (out_ready) begin
          if (r_count == C_LAST) begin
            w_count_nxt      = '0;
            w_frame_done_nxt = 1'b1;
`ifdef ADDR_INV_AUTORESTART_EN
            w_state_nxt      = S_RUN;
`else
            w_state_nxt      = S_IDLE;
`endif
          end else begin
            w_count_nxt = r_count + 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_count_nxt = '0;
      end
    endcase
  end

  // Inverse of the write-side radix-4 stage interleavers.
  always_comb begin
    w_perm = r_count;
    case (r_mode_q)
      3'd0:    w_perm = {r_count[9:0], r_count[11:10]};
      3'd1:    w_perm = {r_count[11:10], r_count[7:0], r_count[9:8]};
      3'd2:    w_perm = {r_count[11:8], r_count[5:0], r_count[7:6]};
      3'd3:    w_perm = {r_count[11:6], r_count[3:0], r_count[5:4]};
      3'd4:    w_perm = {r_count[11:4], r_count[1:0], r_count[3:2]};
      3'd6:    w_perm = {r_count[1:0], r_count[3:2], r_count[5:4],
                         r_count[7:6], r_count[9:8], r_count[11:10]};
      default: w_perm = r_count;
    endcase
  end

  assign addr_valid  = (r_state == S_RUN);
  assign busy        = (r_state == S_RUN);
  assign linear_addr = r_count;
  assign addr        = (r_state == S_RUN) ? w_perm : '0;
  assign frame_done  = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_addr_inv_gen.sv
// ============================================================================
// Module   : tb_addr_inv_gen
// Brief    : Self-checking bench for addr_inv_gen against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_addr_inv_gen;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  mode;
  logic        abort;
  logic        out_ready;
  logic        addr_valid;
  logic [11:0] addr;
  logic [11:0] linear_addr;
  logic        frame_done;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  // Frame-level model state
  bit m_run;
  bit m_done;
  int m_cnt;
  int m_mode;

  addr_inv_gen #(.ADDRLENGTH(12)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .mode       (mode),
    .abort      (abort),
    .out_ready  (out_ready),
    .addr_valid (addr_valid),
    .addr       (addr),
    .linear_addr(linear_addr),
    .frame_done (frame_done),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Modes 0..4 rotate the low (12-2*mode) bits left by one base-4 digit;
  // mode 6 reverses all six base-4 digits; modes 5/7 pass through.
  function automatic logic [11:0] ref_addr(input int c, input int md);
    int w, low, r, x;
    if (md == 6) begin
      r = 0;
      x = c;
      for (int i = 0; i < 6; i++) begin
        r = r * 4 + x % 4;
        x = x / 4;
      end
      return 12'(r);
    end
    if (md >= 5) return 12'(c);
    w   = 12 - 2 * md;
    low = c % (1 << w);
    r   = ((low * 4) % (1 << w)) + low / (1 << (w - 2));
    return 12'(c - low + r);
  endfunction

  task automatic cycle(input logic s, input logic a, input logic r, input logic [2:0] md);
    start = s; abort = a; out_ready = r; mode = md;
    m_done = 1'b0;
    if (!m_run) begin
      if (s && !a) begin
        m_run = 1'b1; m_cnt = 0; m_mode = int'(md);
      end
    end else if (a) begin
      m_run = 1'b0; m_cnt = 0;
    end else if (r) begin
      if (m_cnt == 4095) begin
        m_cnt = 0; m_done = 1'b1;
`ifndef ADDR_INV_AUTORESTART_EN
        m_run = 1'b0;
`endif
      end else begin
        m_cnt++;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_run = 1'b0; m_done = 1'b0; m_cnt = 0; m_mode = 0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; out_ready = 1'b0; mode = 3'd0;
    model_reset();
    #2;
    vectors++;
    if ({addr_valid, busy, frame_done, linear_addr, addr} !== 27'd0) begin
      errors++;
      $display("FAIL reset_values: got v=%b b=%b d=%b lin=%h addr=%h, want all zero",
               addr_valid, busy, frame_done, linear_addr, addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    // start together with abort must be ignored in IDLE
    cycle(1'b1, 1'b1, 1'b1, 3'd3);
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (busy !== 1'b0 || addr_valid !== 1'b0 || linear_addr !== 12'h000) begin
      errors++;
      $display("FAIL start_with_abort: got b=%b v=%b lin=%h, want 0 0 000",
               busy, addr_valid, linear_addr);
    end
  endtask

  task automatic test_mode0_sequence();
    logic [11:0] want [3];
    want[0] = 12'h000; want[1] = 12'h004; want[2] = 12'h008;
    vectors++;
    if (addr_valid !== 1'b0) begin
      errors++;
      $display("FAIL pre_start_valid: got %b want 0", addr_valid);
    end
    cycle(1'b1, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (addr_valid !== 1'b1 || addr !== want[i]) begin
        errors++;
        $display("FAIL mode0_seq[%0d]: got v=%b addr=%h want v=1 addr=%h",
                 i, addr_valid, addr, want[i]);
      end
      cycle(1'b0, 1'b0, 1'b1, 3'd7);
    end
    cycle(1'b0, 1'b1, 1'b0, 3'd0);
    vectors++;
    if (busy !== 1'b0 || linear_addr !== 12'h000 || addr !== 12'h000) begin
      errors++;
      $display("FAIL abort_idle: got b=%b lin=%h addr=%h want 0 000 000",
               busy, linear_addr, addr);
    end
  endtask

  task automatic test_directed_modes();
    int          md_t [3];
    int          cnt_t[3];
    logic [11:0] exp_t[3];
    md_t[0] = 6; cnt_t[0] = 'h001; exp_t[0] = 12'h400;
    md_t[1] = 1; cnt_t[1] = 'h100; exp_t[1] = 12'h001;
    md_t[2] = 3; cnt_t[2] = 'h010; exp_t[2] = 12'h001;
    for (int k = 0; k < 3; k++) begin
      cycle(1'b1, 1'b0, 1'b1, 3'(md_t[k]));
      // start and mode wiggling during RUN must have no effect
      for (int i = 0; i < cnt_t[k]; i++)
        cycle(1'($urandom), 1'b0, 1'b1, 3'($urandom));
      vectors++;
      if (linear_addr !== 12'(cnt_t[k]) || addr !== exp_t[k]) begin
        errors++;
        $display("FAIL mode%0d_point: got lin=%h addr=%h want lin=%h addr=%h",
                 md_t[k], linear_addr, addr, 12'(cnt_t[k]), exp_t[k]);
      end
      cycle(1'b0, 1'b1, 1'b0, 3'd0);
    end
  endtask

  task automatic test_stall();
    logic [11:0] want;
    want = ref_addr('h123, 2);
    cycle(1'b1, 1'b0, 1'b1, 3'd2);
    for (int i = 0; i < 'h123; i++) cycle(1'b0, 1'b0, 1'b1, 3'd0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0, 3'($urandom));
      vectors++;
      if (linear_addr !== 12'h123 || addr !== want || addr_valid !== 1'b1) begin
        errors++;
        $display("FAIL stall[%0d]: got lin=%h addr=%h v=%b want lin=123 addr=%h v=1",
                 i, linear_addr, addr, addr_valid, want);
      end
    end
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (linear_addr !== 12'h124 || addr !== ref_addr('h124, 2)) begin
      errors++;
      $display("FAIL stall_release: got lin=%h addr=%h want lin=124 addr=%h",
               linear_addr, addr, ref_addr('h124, 2));
    end
    cycle(1'b0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_full_frame();
    bit seen [4096];
    int uniq = 0;
    int bad  = 0;
    for (int i = 0; i < 4096; i++) seen[i] = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 3'd4);
    for (int i = 0; i < 4096; i++) begin
      if (addr_valid !== 1'b1 || linear_addr !== 12'(i) || frame_done !== 1'b0 ||
          addr !== ref_addr(i, 4)) bad++;
      if (!seen[addr]) begin
        seen[addr] = 1'b1;
        uniq++;
      end
      cycle(1'b0, 1'b0, 1'b1, 3'($urandom));
    end
    vectors++;
    if (bad != 0) begin
      errors++;
      $display("FAIL frame_addresses: got %0d bad cycles want 0", bad);
    end
    vectors++;
    if (uniq != 4096) begin
      errors++;
      $display("FAIL frame_distinct: got %0d distinct want 4096", uniq);
    end
    vectors++;
`ifdef ADDR_INV_AUTORESTART_EN
    if (frame_done !== 1'b1 || busy !== 1'b1 || addr_valid !== 1'b1 || linear_addr !== 12'h000) begin
      errors++;
      $display("FAIL frame_end: got d=%b b=%b v=%b lin=%h want d=1 b=1 v=1 lin=000",
               frame_done, busy, addr_valid, linear_addr);
    end
`else
    if (frame_done !== 1'b1 || busy !== 1'b0 || addr_valid !== 1'b0 || linear_addr !== 12'h000) begin
      errors++;
      $display("FAIL frame_end: got d=%b b=%b v=%b lin=%h want d=1 b=0 v=0 lin=000",
               frame_done, busy, addr_valid, linear_addr);
    end
`endif
    cycle(1'b0, 1'b0, 1'b0, 3'd0);
    vectors++;
    if (frame_done !== 1'b0) begin
      errors++;
      $display("FAIL frame_done_pulse: got %b want 0", frame_done);
    end
    cycle(1'b0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_abort_last();
    cycle(1'b1, 1'b0, 1'b1, 3'($urandom));
    for (int i = 0; i < 4095; i++) cycle(1'b0, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (linear_addr !== 12'hFFF) begin
      errors++;
      $display("FAIL abort_last_reach: got lin=%h want fff", linear_addr);
    end
    cycle(1'b0, 1'b1, 1'b1, 3'd0);
    vectors++;
    if (busy !== 1'b0 || frame_done !== 1'b0 || linear_addr !== 12'h000) begin
      errors++;
      $display("FAIL abort_last: got b=%b d=%b lin=%h want 0 0 000",
               busy, frame_done, linear_addr);
    end
    cycle(1'b0, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (frame_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_last_after: got d=%b b=%b want 0 0", frame_done, busy);
    end
  endtask

  task automatic test_reset_mid();
    cycle(1'b1, 1'b0, 1'b1, 3'd6);
    for (int i = 0; i < 'h800; i++) cycle(1'b0, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (linear_addr !== 12'h800 || addr !== ref_addr('h800, 6)) begin
      errors++;
      $display("FAIL reset_mid_reach: got lin=%h addr=%h want 800 %h",
               linear_addr, addr, ref_addr('h800, 6));
    end
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    vectors++;
    if ({addr_valid, busy, frame_done, linear_addr, addr} !== 27'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got v=%b b=%b d=%b lin=%h addr=%h want all zero",
               addr_valid, busy, frame_done, linear_addr, addr);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 1'b0, 1'b1, 3'd0);
      vectors++;
      if (busy !== 1'b0 || frame_done !== 1'b0 || addr_valid !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle[%0d]: got b=%b d=%b v=%b want 0 0 0",
                 i, busy, frame_done, addr_valid);
      end
    end
    cycle(1'b1, 1'b0, 1'b1, 3'd0);
    vectors++;
    if (busy !== 1'b1 || linear_addr !== 12'h000) begin
      errors++;
      $display("FAIL reset_mid_restart: got b=%b lin=%h want 1 000", busy, linear_addr);
    end
    cycle(1'b0, 1'b1, 1'b0, 3'd0);
  endtask

  task automatic test_random();
    logic s, a, r;
    for (int i = 0; i < 3000; i++) begin
      s = ($urandom % 4) == 0;
      a = ($urandom % 128) == 0;
      r = ($urandom % 4) != 0;
      cycle(s, a, r, 3'($urandom));
      vectors++;
      if ({addr_valid, busy, frame_done, linear_addr, addr} !==
          {m_run, m_run, m_done, 12'(m_cnt), ref_addr(m_cnt, m_mode)}) begin
        errors++;
        $display("FAIL random[%0d]: got v=%b b=%b d=%b lin=%h addr=%h want v=%b d=%b lin=%h addr=%h",
                 i, addr_valid, busy, frame_done, linear_addr, addr,
                 m_run, m_done, 12'(m_cnt), ref_addr(m_cnt, m_mode));
      end
    end
  endtask

  initial begin
    test_reset();
    test_mode0_sequence();
    test_directed_modes();
    test_stall();
    test_full_frame();
    test_abort_last();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

`default_nettype wire
